// File: rtl/shifter_pipelined.sv
// rtl/shifter_pipelined.sv - pipelined barrel shifter with valid/ready flow control
//
// Purpose: shifts or rotates a WIDTH-bit operand by 0..WIDTH-1 positions through
// CW = log2(WIDTH) registered stages. Stage k shifts by 2^k when count bit k is set.
// Bubbles collapse, so any empty stage accepts data even while the output stalls.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; empties every stage
//   in_valid   operand and controls are valid this cycle
//   in_ready   block accepts the operand this cycle (never depends on in_valid)
//   in_data    operand to shift
//   in_cnt     shift amount, 0..WIDTH-1
//   in_mode    00 SLL, 01 SRL, 10 ROL, 11 SRA
//   out_valid  out_data holds a completed result (last stage register)
//   out_ready  downstream consumes the result this cycle
//   out_data   shifted result (last stage register)

module shifter_pipelined #(
  parameter int WIDTH = 16,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CW-1:0]    in_cnt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  // One fixed-distance step of the barrel. Because each step of an arithmetic
  // shift preserves the MSB, using the current MSB as fill reproduces the
  // original sign bit across all stages.
  function automatic logic [WIDTH-1:0] shift_step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input int               s
  );
    logic [WIDTH-1:0] r;
    case (mode)
      MODE_SLL: r = d << s;
      MODE_SRL: r = d >> s;
      MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
      MODE_SRA: r = $signed(d) >>> s;
      default:  r = d;
    endcase
    return r;
  endfunction

  // Stage registers. The count is stored pre-shifted so that bit 0 is always
  // the bit the next stage consumes; the last stage only needs its data, so
  // count and mode are kept for stages 0..CW-2.
  logic [CW-1:0]    v_q;
  logic [WIDTH-1:0] data_q [CW];
  logic [CW-1:0]    cnt_q  [CW-1];
  logic [1:0]       mode_q [CW-1];

  // Next-state candidates: what stage k captures if it loads.
  logic [CW-1:0]    v_d;
  logic [WIDTH-1:0] data_d [CW];
  logic [CW-1:0]    cnt_d  [CW-1];
  logic [1:0]       mode_d [CW-1];

  // Stage load enables.
  logic [CW-1:0]    ld;

  for (genvar k = 0; k < CW; k++) begin : g_stage
    logic             src_v;
    logic [WIDTH-1:0] src_data;
    logic             src_bit;
    logic [1:0]       src_mode;

    if (k == 0) begin : g_in
      assign src_v    = in_valid;
      assign src_data = in_data;
      assign src_bit  = in_cnt[0];
      assign src_mode = in_mode;
      assign cnt_d[0] = in_cnt >> 1;
    end else begin : g_prev
      assign src_v    = v_q[k-1];
      assign src_data = data_q[k-1];
      assign src_bit  = cnt_q[k-1][0];
      assign src_mode = mode_q[k-1];
      if (k < CW - 1) begin : g_cnt
        assign cnt_d[k] = cnt_q[k-1] >> 1;
      end
    end

    if (k < CW - 1) begin : g_mode
      assign mode_d[k] = src_mode;
    end

    // Stage k can load when the output drains or any stage from k to the end
    // is empty: an empty slot downstream means everything ahead of it moves.
    // Written without referencing ld[k+1] so there is no chain through ld.
    assign ld[k]     = out_ready || !(&v_q[CW-1:k]);
    assign v_d[k]    = src_v;
    assign data_d[k] = src_bit ? shift_step(src_data, src_mode, 1 << k) : src_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < CW; k++) begin
        data_q[k] <= '0;
      end
      for (int k = 0; k < CW - 1; k++) begin
        cnt_q[k]  <= '0;
        mode_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CW; k++) begin
        if (ld[k]) begin
          v_q[k] <= v_d[k];
          // Payload only moves with a valid operand; bubbles leave it untouched.
          if (v_d[k]) begin
            data_q[k] <= data_d[k];
          end
        end
      end
      for (int k = 0; k < CW - 1; k++) begin
        if (ld[k] && v_d[k]) begin
          cnt_q[k]  <= cnt_d[k];
          mode_q[k] <= mode_d[k];
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[CW-1];
  assign out_data  = data_q[CW-1];

endmodule

// File: tb/tb_shifter_pipelined.sv
// tb/tb_shifter_pipelined.sv - self-checking bench for shifter_pipelined

module tb_shifter_pipelined;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];

  shifter_pipelined #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // Bit-by-bit reference: 00 SLL, 01 SRL, 10 ROL, 11 SRA.
  function automatic logic [15:0] model(input logic [15:0] d, input int cnt, input logic [1:0] m);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      case (m)
        2'b00:   r[i] = (i >= cnt) ? d[i-cnt] : 1'b0;
        2'b01:   r[i] = (i + cnt < 16) ? d[i+cnt] : 1'b0;
        2'b10:   r[i] = d[(i - cnt + 16) % 16];
        default: r[i] = (i + cnt < 16) ? d[i+cnt] : d[15];
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++;
    if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h8001;
    in_cnt    = 4'd2;
    in_mode   = 2'b01;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      #1;
      total++;
      if (out_valid !== (c == 4)) begin
        bad++; $display("FAIL single_latency c=%0d got=%b exp=%b", c, out_valid, (c == 4));
      end
      if (c == 4) begin
        total++;
        if (out_data !== 16'h2000) begin bad++; $display("FAIL single_data got=%h exp=2000", out_data); end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d [4];
    logic [3:0]  n [4];
    logic [1:0]  m [4];
    logic [15:0] e [4];
    logic [15:0] exp;
    d[0] = 16'h8000; n[0] = 4'd15; m[0] = 2'b11; e[0] = 16'hFFFF;
    d[1] = 16'h8001; n[1] = 4'd1;  m[1] = 2'b10; e[1] = 16'h0003;
    d[2] = 16'h00F0; n[2] = 4'd12; m[2] = 2'b00; e[2] = 16'h0000;
    d[3] = 16'h1234; n[3] = 4'd0;  m[3] = 2'b11; e[3] = 16'h1234;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 4);
      if (c < 4) begin
        in_data = d[c]; in_cnt = n[c]; in_mode = m[c];
      end
      #1;
      total++;
      if (out_valid !== (c >= 4 && c <= 7)) begin
        bad++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 4 && c <= 7));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp = sb.pop_front();
        total++;
        if (out_data !== exp) begin bad++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, out_data, exp); end
      end
      if (in_valid) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready c=%0d got=%b exp=1", c, in_ready); end
        if (in_ready) sb.push_back(e[c]);
      end
      step();
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [15:0] exp;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1;
      in_data  = 16'hA5C3 ^ 16'(acc * 16'h1111);
      in_cnt   = 4'(acc + 3);
      in_mode  = 2'(acc);
      #1;
      if (c >= 4) begin
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_stall_valid c=%0d got=%b exp=1", c, out_valid); end
        total++;
        if (out_data !== sb[0]) begin bad++; $display("FAIL bp_stall_data c=%0d got=%h exp=%h", c, out_data, sb[0]); end
      end
      if (in_ready) begin
        sb.push_back(model(in_data, int'(in_cnt), in_mode));
        acc++;
      end
      step();
    end
    #1;
    total++;
    if (acc !== 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", acc); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_fifth_accept got=%b exp=1", in_ready); end
    exp = sb.pop_front();
    total++;
    if (out_data !== exp) begin bad++; $display("FAIL bp_drain0 got=%h exp=%h", out_data, exp); end
    if (in_ready) sb.push_back(model(in_data, int'(in_cnt), in_mode));
    step();
    in_valid = 1'b0;
    for (int d = 1; d <= 6; d++) begin
      #1;
      total++;
      if (out_valid !== (d < 5)) begin bad++; $display("FAIL bp_drain_valid d=%0d got=%b exp=%b", d, out_valid, (d < 5)); end
      if (out_valid && sb.size() != 0) begin
        exp = sb.pop_front();
        total++;
        if (out_data !== exp) begin bad++; $display("FAIL bp_drain_data d=%0d got=%h exp=%h", d, out_data, exp); end
      end
      step();
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL bp_leftover got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_bubble();
    int acc;
    logic [15:0] exp;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c == 0) || (c == 2) || (c >= 6);
      in_data  = 16'($urandom);
      in_cnt   = 4'($urandom);
      in_mode  = 2'($urandom);
      #1;
      total++;
      if (in_ready !== (acc < 4)) begin bad++; $display("FAIL bubble_in_ready c=%0d got=%b exp=%b", c, in_ready, (acc < 4)); end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, int'(in_cnt), in_mode));
        acc++;
      end
      step();
    end
    total++;
    if (acc !== 4) begin bad++; $display("FAIL bubble_accepted got=%0d exp=4", acc); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int d = 0; d < 6; d++) begin
      #1;
      total++;
      if (out_valid !== (d < 4)) begin bad++; $display("FAIL bubble_drain_valid d=%0d got=%b exp=%b", d, out_valid, (d < 4)); end
      if (out_valid && sb.size() != 0) begin
        exp = sb.pop_front();
        total++;
        if (out_data !== exp) begin bad++; $display("FAIL bubble_drain_data d=%0d got=%h exp=%h", d, out_data, exp); end
      end
      step();
    end
    sb.delete();
  endtask

  task automatic test_reset_midstream();
    logic [15:0] exp;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 3);
      in_data  = 16'h5A5A + 16'(c);
      in_cnt   = 4'(c + 1);
      in_mode  = 2'(c);
      #1;
      step();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_inflight got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_async_drop got=%b exp=0", out_valid); end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0);
      in_data  = 16'h00FF;
      in_cnt   = 4'd4;
      in_mode  = 2'b00;
      #1;
      total++;
      if (out_valid !== (c == 4)) begin bad++; $display("FAIL rstmid_valid c=%0d got=%b exp=%b", c, out_valid, (c == 4)); end
      if (out_valid && sb.size() != 0) begin
        exp = sb.pop_front();
        total++;
        if (out_data !== exp) begin bad++; $display("FAIL rstmid_data got=%h exp=%h", out_data, exp); end
      end
      if (in_valid) begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        if (in_ready) sb.push_back(16'h0FF0);
      end
      step();
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rstmid_leftover got=%0d exp=0", sb.size()); sb.delete(); end
  endtask

  task automatic test_random();
    int sent;
    int cyc;
    logic [15:0] exp;
    sent = 0;
    cyc  = 0;
    while ((sent < 10000 || sb.size() != 0) && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 99) < 75);
      in_data   = 16'($urandom);
      in_cnt    = 4'($urandom);
      in_mode   = 2'($urandom);
      out_ready = ($urandom_range(0, 99) < 70);
      #1;
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rand_unexpected cyc=%0d got=%h exp=none", cyc, out_data);
        end else begin
          exp = sb.pop_front();
          if (out_data !== exp) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, exp); end
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(in_data, int'(in_cnt), in_mode));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (sent !== 10000) begin bad++; $display("FAIL rand_sent got=%0d exp=10000", sent); end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL rand_drained got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cnt    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_bubble();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
